// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame writer.
//   OUT_W_DEF / OUT_H_DEF : default output frame geometry
//   PXL_W                 : width of the signed gradient sample
//   PIX_MAX               : brightest stored pixel value
//   state_e               : frame writer state (ACCEPT while filling, DONE when full)
package sobel_pkg;

  localparam int          OUT_W_DEF = 3;
  localparam int          OUT_H_DEF = 3;
  localparam int          PXL_W     = 16;
  localparam logic [7:0]  PIX_MAX   = 8'hFF;

  typedef enum logic {
    ACCEPT = 1'b0,
    DONE   = 1'b1
  } state_e;

endpackage

// File: rtl/sobel_frame_writer_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
//   clk_i     : clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   re_i      : read enable (read register loads only when set)
//   raddr_i   : read address
//   rdata_o   : registered read data
// Written in the plain form block-RAM inference expects (no reset on storage).
module frame_ram #(
  parameter int DEPTH  = 9,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_frame_writer.sv
// Sobel frame writer: converts the signed gradient stream into 8-bit pixels,
// stores one OUT_W x OUT_H frame in raster order and serves it for readback.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset (control state only)
//   pxl_in     : two's-complement gradient sample
//   valid      : pxl_in valid this cycle
//   bin_en     : 1 = binarize against thresh, 0 = saturated magnitude
//   thresh     : binarization threshold
//   clear      : pulse, re-arm for a new frame
//   rd_en      : read request (honoured only when the frame is complete)
//   rd_addr    : read address, row*OUT_W+col
//   rd_data    : read data, one cycle after rd_en
//   rd_valid   : rd_data valid
//   col / row  : position of the next write
//   frame_done : frame complete (level)
//   overflow   : sticky, a sample arrived while the frame was complete
module sobel_frame_writer
  import sobel_pkg::*;
#(
  parameter int OUT_W  = OUT_W_DEF,
  parameter int OUT_H  = OUT_H_DEF,
  parameter int ADDR_W = $clog2(OUT_W * OUT_H)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              pxl_in,
  input  logic                     valid,
  input  logic                     bin_en,
  input  logic [7:0]               thresh,
  input  logic                     clear,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(OUT_W)-1:0] col,
  output logic [$clog2(OUT_H)-1:0] row,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int COL_W = $clog2(OUT_W);
  localparam int ROW_W = $clog2(OUT_H);
  localparam int DEPTH = OUT_W * OUT_H;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(OUT_H - 1);
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

  // |s| as an unsigned 16-bit value; 0x8000 maps to 32768 without overflow.
  function automatic logic [PXL_W-1:0] abs_mag(input logic signed [PXL_W-1:0] s);
    logic [PXL_W-1:0] u;
    u = s;
    return s[PXL_W-1] ? (~u + 16'd1) : u;
  endfunction

  function automatic logic [7:0] sat8(input logic [PXL_W-1:0] mag);
    return (mag > 16'd255) ? PIX_MAX : mag[7:0];
  endfunction

  // Threshold compare on the full magnitude, not the saturated byte.
  function automatic logic [7:0] binarize(input logic [PXL_W-1:0] mag,
                                          input logic [7:0]       th);
    return (mag >= {8'd0, th}) ? PIX_MAX : 8'd0;
  endfunction

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             overflow_q, overflow_d;
  logic             rd_valid_q, rd_valid_d;
  logic             oor_q, oor_d;

  logic signed [PXL_W-1:0] pxl_s;
  logic [PXL_W-1:0]        mag;
  logic [7:0]              pix;
  logic [ADDR_W-1:0]       wr_addr;
  logic [ADDR_W-1:0]       ram_raddr;
  logic [7:0]              ram_rdata;
  logic                    rd_oor;
  logic                    we;
  logic                    re;

  assign pxl_s   = signed'(pxl_in);
  assign mag     = abs_mag(pxl_s);
  assign pix     = bin_en ? binarize(mag, thresh) : sat8(mag);
  assign wr_addr = ADDR_W'(row_q) * ADDR_W'(OUT_W) + ADDR_W'(col_q);

  // Out-of-range reads never touch the RAM; they return 0 with rd_valid set.
  assign rd_oor    = ({1'b0, rd_addr} >= DEPTH_V);
  assign ram_raddr = rd_oor ? '0 : rd_addr;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    oor_d      = 1'b0;
    we         = 1'b0;
    re         = 1'b0;

    if (clear) begin
      // clear beats both an incoming sample and a read request
      state_d    = ACCEPT;
      col_d      = '0;
      row_d      = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCEPT: begin
          if (valid) begin
            we = 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d   = '0;
                state_d = DONE;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (valid) begin
            overflow_d = 1'b1;
          end
          if (rd_en) begin
            re         = ~rd_oor;
            rd_valid_d = 1'b1;
            oor_d      = rd_oor;
          end
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCEPT;
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      oor_q      <= oor_d;
    end
  end

  frame_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (wr_addr),
    .wdata_i (pix),
    .re_i    (re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // RAM output register is not reset, so mask it whenever no read is live.
  assign rd_data    = (rd_valid_q && !oor_q) ? ram_rdata : 8'd0;
  assign rd_valid   = rd_valid_q;
  assign col        = col_q;
  assign row        = row_q;
  assign frame_done = (state_q == DONE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sobel_frame_writer.sv
module tb_sobel_frame_writer;

  localparam int OUT_W  = 3;
  localparam int OUT_H  = 3;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [15:0]       pxl_in = '0;
  logic              valid = 1'b0;
  logic              bin_en = 1'b0;
  logic [7:0]        thresh = '0;
  logic              clear = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [1:0]        col;
  logic [1:0]        row;
  logic              frame_done;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sobel_frame_writer #(.OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pxl_in     (pxl_in),
    .valid      (valid),
    .bin_en     (bin_en),
    .thresh     (thresh),
    .clear      (clear),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .col        (col),
    .row        (row),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample, then `gap` idle cycles; position checked after the gap.
  task automatic send(input logic [15:0] s, input logic b, input logic [7:0] th,
                      input int gap);
    pxl_in = s; bin_en = b; thresh = th; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Back-to-back reads of addr 0..n-1, each compared against the scoreboard.
  task automatic read_frame(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1; rd_addr = ADDR_W'(i);
      tick();
      chk($sformatf("rd_valid[%0d]", i), rd_valid, 1);
      if (exp_q.size() == 0) begin
        chk($sformatf("scoreboard_empty[%0d]", i), 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rd_data[%0d]", i), rd_data, e);
      end
    end
    rd_en = 1'b0;
    tick();
    chk("rd_valid_drop", rd_valid, 0);
  endtask

  initial begin
    // reset
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);

    // frame of 1..9, contiguous
    for (int i = 1; i <= 9; i++) begin
      send(16'(i), 1'b0, 8'd0, 0);
      exp_q.push_back(8'(i));
      if (i == 8) chk("fd_before_last", frame_done, 0);
    end
    chk("fd_after_last", frame_done, 1);
    chk("col_wrap_done", col, 0);
    chk("row_wrap_done", row, 0);
    read_frame(9);

    // out-of-range read returns 0 with valid
    rd_en = 1'b1; rd_addr = 4'd12;
    tick();
    rd_en = 1'b0;
    chk("oor_valid", rd_valid, 1);
    chk("oor_data", rd_data, 0);

    // overflow in DONE, contents untouched
    send(16'h0077, 1'b0, 8'd0, 0);
    chk("overflow_set", overflow, 1);
    send(16'h0066, 1'b0, 8'd0, 0);
    chk("overflow_sticky", overflow, 1);
    for (int i = 1; i <= 9; i++) exp_q.push_back(8'(i));
    read_frame(9);

    // clear together with rd_en: clear wins
    clear = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    clear = 1'b0; rd_en = 1'b0;
    chk("clr_rd_valid", rd_valid, 0);
    chk("clr_frame_done", frame_done, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_col", col, 0);
    chk("clr_row", row, 0);

    // clear together with valid: sample dropped
    clear = 1'b1; valid = 1'b1; pxl_in = 16'h0055;
    tick();
    clear = 1'b0; valid = 1'b0;
    chk("clr_valid_col", col, 0);

    // conversion frame, one idle cycle between samples
    begin
      logic [15:0] s_tab [9] = '{16'h0123, 16'hFFF6, 16'h8000, 16'h00FF, 16'h0000,
                                 16'h0013, 16'h0014, 16'hFFEC, 16'h0400};
      logic [7:0]  e_tab [9] = '{8'd255, 8'd10, 8'd255, 8'd255, 8'd0,
                                 8'd0, 8'd255, 8'd255, 8'd255};
      for (int k = 0; k < 9; k++) begin
        send(s_tab[k], (k >= 5), 8'd20, 1);
        exp_q.push_back(e_tab[k]);
        chk($sformatf("seq_col[%0d]", k), col, ((k + 1) % 3));
        chk($sformatf("seq_row[%0d]", k), row, (((k + 1) / 3) % 3));
        chk($sformatf("seq_fd[%0d]", k), frame_done, (k == 8));
      end
    end
    read_frame(9);

    // reset in mid-frame
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0033, 1'b0, 8'd0, 0);
    chk("mid_col", col, 1);
    chk("mid_row", row, 1);
    rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    rd_en = 1'b0;
    chk("accept_rd_valid", rd_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_col", col, 0);
    chk("mid_rst_row", row, 0);
    chk("mid_rst_fd", frame_done, 0);
    for (int i = 0; i < 9; i++) begin
      send(16'(16'h10 + i), 1'b0, 8'd0, 0);
      exp_q.push_back(8'(8'h10 + i));
    end
    chk("refill_fd", frame_done, 1);
    read_frame(9);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_writer.md
# sobel_frame_writer

Receiving end of the convolution output stream: consumes the signed 16-bit gradient samples and `valid` strobe produced by `conv`, converts each to an 8-bit magnitude (optionally binarized), and writes them in raster order into an internal frame buffer of OUT_W×OUT_H pixels. When the frame is complete it raises `frame_done` and serves the stored image through a registered read port for the host or display path.

## Interface
- OUT_W, 3, output frame width (input image width − 2)
- OUT_H, 3, output frame height (input image height − 2)
- ADDR_W, $clog2(OUT_W*OUT_H), frame buffer address width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pxl_in  in  16  two's-complement gradient sample from `conv.pxl_out`
- valid  in  1  `pxl_in` is valid this cycle
- bin_en  in  1  1: binarize against `thresh`; 0: saturated magnitude
- thresh  in  8  binarization threshold
- clear  in  1  one-cycle pulse: discard done status and arm for a new frame
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address, raster order (row*OUT_W+col)
- rd_data  out  8  read data
- rd_valid  out  1  `rd_data` valid
- col  out  $clog2(OUT_W)  column of next write
- row  out  $clog2(OUT_H)  row of next write
- frame_done  out  1  frame complete, level
- overflow  out  1  sticky: `valid` seen while in DONE

## Operation
- States: ACCEPT (reset state), DONE.
- ACCEPT: each cycle with `valid`=1, write pixel to address `row*OUT_W+col`, advance col; col wraps OUT_W−1→0 with row+1. On write of address OUT_W*OUT_H−1 → DONE, col/row return to 0.
- `valid`=0 cycles: no write, counters hold; gaps of any length are legal.
- Pixel conversion: mag = |pxl_in|; 0x8000 treated as 32768. bin_en=0: out = min(mag,255). bin_en=1: out = (mag ≥ thresh) ? 255 : 0. Compare uses the full 16-bit magnitude, not the saturated value.
- DONE: `frame_done`=1; writes blocked; any `valid`=1 sets `overflow`, RAM unchanged.
- `clear` (either state): → ACCEPT, col=row=0, frame_done=0, overflow=0. `clear` with `valid` in the same cycle: clear wins, sample dropped.
- Reads allowed only in DONE; `rd_en` in ACCEPT is ignored (rd_valid stays 0). Out-of-range `rd_addr` returns 0 with rd_valid=1.
- `clear` and `rd_en` in the same cycle: clear wins, rd_valid=0 next cycle.
- Reset mid-frame: state ACCEPT, counters 0, flags 0; RAM contents not cleared (not observable until refilled).

## Timing
- Reset values: rd_data=0, rd_valid=0, col=0, row=0, frame_done=0, overflow=0.
- Write: sample accepted on edge where `valid`=1; col/row update on the same edge.
- frame_done rises on the edge that accepts the last sample (visible the cycle after last `valid`).
- Read latency 1: rd_en/rd_addr at edge N → rd_data/rd_valid at edge N+1; back-to-back reads every cycle supported. rd_valid deasserts the cycle after rd_en drops.
- overflow sets on the edge of the offending `valid`.

## Structure
- Shared package `sobel_pkg`: OUT_W/OUT_H defaults, state enum {ACCEPT, DONE}, pixel max constant 8'hFF.
- Sub-module `frame_ram`: simple dual-port RAM, 1 write port, 1 registered read port, depth OUT_W*OUT_H, 8-bit; inferable as block RAM.
- Top: counters, FSM, conversion, read gating.

## Test plan
- Reset, then 9 consecutive `valid` samples 0x0001..0x0009 → frame_done=1 the cycle after the 9th; reads of addr 0..8 return 1..9, rd_valid one cycle after each rd_en.
- Saturation, bin_en=0: 0x0123→255, 0xFFF6 (−10)→10, 0x8000→255, 0x00FF→255, 0x0000→0.
- bin_en=1, thresh=20: inputs 19, 20, 0xFFEC (−20), 0x0400 → 0, 255, 255, 255.
- `valid` every other cycle for 9 samples → col sequence 0,1,2,0,…, row increments at each wrap; frame_done only after 9th accepted sample.
- In DONE, 2 extra `valid` samples → overflow=1, readback unchanged; `clear` → frame_done=0, overflow=0, col=row=0; next frame overwrites from addr 0.
- `reset` after 4 samples → col=row=0, frame_done=0; 9 new samples 0x10..0x18 → readback 0x10..0x18; rd_en during ACCEPT → rd_valid stays 0.
